// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word layout, register-destination
// encodings and the return-address register number.
package pipe_pkg;

  localparam int CTRL_W = 14;

  // Control word, MSB first:
  // regdst[1:0] regwr memrd memwr memtoreg[1:0] alusrc uses_rt aluop[4:0]
  localparam int CTRL_REGDST_LSB   = 12;
  localparam int CTRL_REGWR        = 11;
  localparam int CTRL_MEMRD        = 10;
  localparam int CTRL_MEMWR        = 9;
  localparam int CTRL_MEMTOREG_LSB = 7;
  localparam int CTRL_ALUSRC       = 6;
  localparam int CTRL_USES_RT      = 5;
  localparam int CTRL_ALUOP_LSB    = 0;

  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_RA   = 2'b10;
  localparam logic [1:0] REGDST_ZERO = 2'b11;

  localparam logic [4:0] REG_RA = 5'd31;

  // Destination register an instruction will write; 0 when it does not write.
  function automatic logic [4:0] dest_reg(input logic [CTRL_W-1:0] ctrl,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
    logic [4:0] sel;
    case (ctrl[CTRL_REGDST_LSB +: 2])
      REGDST_RT: sel = rt;
      REGDST_RD: sel = rd;
      REGDST_RA: sel = REG_RA;
      default:   sel = 5'd0;
    endcase
    return ctrl[CTRL_REGWR] ? sel : 5'd0;
  endfunction

endpackage

// File: rtl/idex_stage_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is a
// source of the instruction currently in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memrd,
  input  logic [4:0] ex_wreg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_wreg == id_rs);
  assign rt_match = id_uses_rt & (ex_wreg == id_rt);
  assign hazard   = ex_valid & ex_memrd & (ex_wreg != 5'd0) & (rs_match | rt_match);

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with bubble insertion and a saturating bubble count.
// Define IDEX_LOAD_USE_DETECT_EN to enable load-use stall detection.
module idex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wreg,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_pc4,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic              hazard_stall,
  output logic [15:0]       bubble_cnt
);

`ifdef IDEX_LOAD_USE_DETECT_EN
  hazard_detect u_hazard_detect (
    .ex_valid   (ex_valid),
    .ex_memrd   (ex_ctrl[CTRL_MEMRD]),
    .ex_wreg    (ex_wreg),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_ctrl[CTRL_USES_RT]),
    .hazard     (hazard_stall)
  );
`else
  assign hazard_stall = 1'b0;
`endif

  logic insert_bubble;
  assign insert_bubble = flush_in | hazard_stall;

  // stall_in outranks any bubble request; a held flush must be re-asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_wreg    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      ex_ctrl    <= '0;
      ex_valid   <= 1'b0;
      bubble_cnt <= '0;
    end else if (!stall_in) begin
      if (insert_bubble) begin
        // Data fields deliberately keep their last values on a bubble.
        ex_rs    <= '0;
        ex_rt    <= '0;
        ex_wreg  <= '0;
        ex_ctrl  <= '0;
        ex_valid <= 1'b0;
        if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      end else begin
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_wreg    <= dest_reg(id_ctrl, id_rt, id_rd);
        ex_rs_data <= id_rs_data;
        ex_rt_data <= id_rt_data;
        ex_imm     <= id_imm;
        ex_pc4     <= id_pc4;
        ex_ctrl    <= id_ctrl;
        ex_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed vector table, randomized run against a
// reference model, and bubble-counter saturation.
module tb_idex_stage;

  localparam int W = 5 * 3 + 32 * 4 + 14 + 1 + 16;

`ifdef IDEX_LOAD_USE_DETECT_EN
  localparam int LU = 1;
`else
  localparam int LU = 0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [13:0] id_ctrl;
  logic        stall_in, flush_in;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [13:0] ex_ctrl;
  logic        ex_valid, hazard_stall;
  logic [15:0] bubble_cnt;

  idex_stage dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .stall_in(stall_in), .flush_in(flush_in),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .hazard_stall(hazard_stall),
    .bubble_cnt(bubble_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic last_haz;

  // reference model: what EX should hold
  logic [4:0]  m_rs, m_rt, m_wreg;
  logic [31:0] m_rsd, m_rtd, m_imm, m_pc4;
  logic [13:0] m_ctrl;
  logic        m_valid;
  int          m_cnt;

  function automatic logic [13:0] mk_ctrl(input logic [1:0] regdst, input logic regwr,
                                          input logic memrd, input logic uses_rt);
    return {regdst, regwr, memrd, 1'b0, (memrd ? 2'b01 : 2'b00), memrd, uses_rt, 5'd3};
  endfunction

  function automatic logic model_haz();
    if (LU == 0) return 1'b0;
    return m_valid && m_ctrl[10] && (m_wreg != 0) &&
           ((m_wreg == id_rs) || (id_ctrl[5] && (m_wreg == id_rt)));
  endfunction

  task automatic model_edge(input logic haz);
    int dst;
    if (reset) begin
      m_rs = 0; m_rt = 0; m_wreg = 0; m_rsd = 0; m_rtd = 0; m_imm = 0; m_pc4 = 0;
      m_ctrl = 0; m_valid = 0; m_cnt = 0;
    end else if (stall_in) begin
      // everything held
    end else if (flush_in || haz) begin
      m_rs = 0; m_rt = 0; m_wreg = 0; m_ctrl = 0; m_valid = 0;
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end else begin
      case (id_ctrl[13:12])
        2'd0: dst = id_rt;
        2'd1: dst = id_rd;
        2'd2: dst = 31;
        default: dst = 0;
      endcase
      m_rs = id_rs; m_rt = id_rt; m_wreg = id_ctrl[11] ? dst[4:0] : 5'd0;
      m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm; m_pc4 = id_pc4;
      m_ctrl = id_ctrl; m_valid = 1'b1;
    end
  endtask

  // driver: apply one cycle of ID inputs, check hazard mid-cycle and EX after the edge
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [13:0] ctrl, input bit chk);
    logic [W-1:0] e, got;
    logic h;
    reset = r; stall_in = st; flush_in = fl;
    id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc4 = $urandom;
    @(negedge clk);
    h = model_haz();
    last_haz = hazard_stall;
    if (chk) begin
      total++;
      if (hazard_stall !== h) begin
        bad++;
        $display("FAIL hazard_stall t=%0t got=%b want=%b", $time, hazard_stall, h);
      end
    end
    model_edge(h);
    exp_q.push_back({m_rs, m_rt, m_wreg, m_rsd, m_rtd, m_imm, m_pc4, m_ctrl, m_valid, m_cnt[15:0]});
    @(posedge clk);
    #1;
    got = {ex_rs, ex_rt, ex_wreg, ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_ctrl, ex_valid, bubble_cnt};
    e = exp_q.pop_front();
    if (chk) begin
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL ex_outputs t=%0t got=%h want=%h", $time, got, e);
      end
    end
  endtask

  typedef struct {
    logic r, st, fl;
    logic [4:0] rs, rt, rd;
    logic [13:0] ctrl;
    logic exp_haz;
    logic exp_valid;
    logic [4:0] exp_wreg;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [13:0] c_lw, c_r, c_r_nort, c_r_nowr, c_ra, c_zero;
    logic [4:0] rs, rt, rd;
    logic [13:0] rc;
    c_lw     = mk_ctrl(2'b00, 1'b1, 1'b1, 1'b0);
    c_r      = mk_ctrl(2'b01, 1'b1, 1'b0, 1'b1);
    c_r_nort = mk_ctrl(2'b01, 1'b1, 1'b0, 1'b0);
    c_r_nowr = mk_ctrl(2'b01, 1'b0, 1'b0, 1'b1);
    c_ra     = mk_ctrl(2'b10, 1'b1, 1'b0, 1'b0);
    c_zero   = mk_ctrl(2'b11, 1'b1, 1'b0, 1'b0);
    //          r  st fl  rs  rt  rd  ctrl      haz    valid            wreg              cnt
    vecs[0]  = '{1, 0, 0,  5,  8,  9, c_lw,     1'b0, 1'b0,            5'd0,             16'(0)};
    vecs[1]  = '{1, 1, 1,  8,  8,  8, c_r,      1'b0, 1'b0,            5'd0,             16'(0)};
    vecs[2]  = '{0, 0, 0,  1,  2,  9, c_r,      1'b0, 1'b1,            5'd9,             16'(0)};
    vecs[3]  = '{0, 0, 0,  1,  2,  9, c_r_nowr, 1'b0, 1'b1,            5'd0,             16'(0)};
    vecs[4]  = '{0, 0, 0,  3,  8,  4, c_lw,     1'b0, 1'b1,            5'd8,             16'(0)};
    vecs[5]  = '{0, 0, 0,  8,  4, 10, c_r,      1'(LU), 1'(1 - LU),    (LU ? 5'd0 : 5'd10), 16'(LU)};
    vecs[6]  = '{0, 0, 0,  8,  4, 10, c_r,      1'b0, 1'b1,            5'd10,            16'(LU)};
    vecs[7]  = '{0, 0, 0,  3,  8,  4, c_lw,     1'b0, 1'b1,            5'd8,             16'(LU)};
    vecs[8]  = '{0, 0, 0,  1,  8, 11, c_r_nort, 1'b0, 1'b1,            5'd11,            16'(LU)};
    vecs[9]  = '{0, 0, 0,  3,  8,  4, c_lw,     1'b0, 1'b1,            5'd8,             16'(LU)};
    vecs[10] = '{0, 0, 1,  1,  8, 12, c_r,      1'(LU), 1'b0,          5'd0,             16'(LU + 1)};
    vecs[11] = '{0, 0, 0,  1,  2, 13, c_r,      1'b0, 1'b1,            5'd13,            16'(LU + 1)};
    vecs[12] = '{0, 1, 1,  4,  5,  6, c_lw,     1'b0, 1'b1,            5'd13,            16'(LU + 1)};
    vecs[13] = '{0, 1, 1,  4,  5,  6, c_lw,     1'b0, 1'b1,            5'd13,            16'(LU + 1)};
    vecs[14] = '{0, 1, 1,  4,  5,  6, c_lw,     1'b0, 1'b1,            5'd13,            16'(LU + 1)};
    vecs[15] = '{0, 0, 1,  4,  5,  6, c_lw,     1'b0, 1'b0,            5'd0,             16'(LU + 2)};
    vecs[16] = '{0, 0, 0,  1,  2,  3, c_ra,     1'b0, 1'b1,            5'd31,            16'(LU + 2)};
    vecs[17] = '{0, 0, 0,  1,  2,  3, c_zero,   1'b0, 1'b1,            5'd0,             16'(LU + 2)};
    vecs[18] = '{0, 0, 0,  1,  7,  3, c_lw,     1'b0, 1'b1,            5'd7,             16'(LU + 2)};
    vecs[19] = '{1, 1, 1,  7,  7,  7, c_r,      1'b0, 1'b0,            5'd0,             16'(0)};

    m_rs = 0; m_rt = 0; m_wreg = 0; m_rsd = 0; m_rtd = 0; m_imm = 0; m_pc4 = 0;
    m_ctrl = 0; m_valid = 0; m_cnt = 0;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].r, vecs[i].st, vecs[i].fl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].ctrl, 1'b1);
      if (!vecs[i].r) begin
        total++;
        if (last_haz !== vecs[i].exp_haz) begin
          bad++;
          $display("FAIL vec%0d_hazard got=%b want=%b", i, last_haz, vecs[i].exp_haz);
        end
      end
      total++;
      if (ex_valid !== vecs[i].exp_valid || ex_wreg !== vecs[i].exp_wreg ||
          bubble_cnt !== vecs[i].exp_cnt) begin
        bad++;
        $display("FAIL vec%0d_ex got valid=%b wreg=%0d cnt=%0d want valid=%b wreg=%0d cnt=%0d",
                 i, ex_valid, ex_wreg, bubble_cnt, vecs[i].exp_valid, vecs[i].exp_wreg, vecs[i].exp_cnt);
      end
    end

    // randomized run against the model; small register range makes hazards common
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 3) == 0) ? 5'd8 : 5'($urandom_range(0, 3));
      rt = ($urandom_range(0, 3) == 0) ? 5'd8 : 5'($urandom_range(0, 3));
      rd = ($urandom_range(0, 2) == 0) ? 5'd8 : 5'($urandom_range(0, 31));
      rc = 14'($urandom);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), rs, rt, rd, rc, 1'b1);
    end

    // counter saturation
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, c_r, 1'b1);
    for (int i = 0; i < 65535; i++) step(1'b0, 1'b0, 1'b1, 0, 0, 0, c_r, 1'b0);
    total++;
    if (bubble_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL cnt_reach_max got=%h want=ffff", bubble_cnt);
    end
    step(1'b0, 1'b0, 1'b1, 0, 0, 0, c_r, 1'b1);
    total++;
    if (bubble_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL cnt_saturate got=%h want=ffff", bubble_cnt);
    end
    step(1'b0, 1'b1, 1'b1, 0, 0, 0, c_r, 1'b1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
